// File: rtl/intc_benes_route_loader_pkg.sv
// Shared constants, command codes and FSM encoding for the Benes route loader.
package intc_benes_route_loader_pkg;

  localparam int STAGE_NUM = 9;
  localparam int CYCLES    = 2;
  localparam int CMD_W     = 8;
  localparam int DATA_W    = 32;

  localparam logic [CMD_W-1:0] COMMAND_SET_ROUTE    = 8'd30;
  localparam logic [CMD_W-1:0] COMMAND_COMMIT_ROUTE = 8'd31;

  localparam int ROUTE_ERR_DROP       = 0;
  localparam int ROUTE_ERR_STAGE      = 1;
  localparam int ROUTE_ERR_INCOMPLETE = 2;

  typedef enum logic [1:0] {
    ROUTE_IDLE       = 2'd0,
    ROUTE_WAIT_DRAIN = 2'd1,
    ROUTE_SWAP       = 2'd2,
    ROUTE_STAGGER    = 2'd3
  } route_state_e;

endpackage

// File: rtl/intc_benes_route_loader_if.sv
// Command/data port carrying route commands into the loader.
interface intc_benes_route_loader_if
  import intc_benes_route_loader_pkg::*;
();
  logic              valid;
  logic [CMD_W-1:0]  command;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;

  modport master (output valid, command, data0, data1);
  modport slave  (input  valid, command, data0, data1);
endinterface

// File: rtl/intc_benes_route_loader_shadow_bank.sv
// Shadow select registers with a per-stage written mask; full mask gates a commit.
module intc_route_shadow_bank #(
  parameter int STAGE_NUM = 9,
  parameter int SEL_W     = 16,
  parameter int IDX_W     = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_stage,
  input  logic [SEL_W-1:0]                    wr_module,
  input  logic [SEL_W-1:0]                    wr_slot,
  input  logic                                mask_clr,
  output logic [0:STAGE_NUM-1][SEL_W-1:0]     module_shadow,
  output logic [0:STAGE_NUM-1][SEL_W-1:0]     slot_shadow,
  output logic                                mask_full
);

  logic [STAGE_NUM-1:0] mask;

  // NOTE: the shadow array is reset like any control register because a
  // commit after reset must never expose stale routing to the network.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      module_shadow <= '0;
      slot_shadow   <= '0;
      mask          <= '0;
    end else begin
      if (mask_clr) mask <= '0;
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (wr_en && wr_stage == IDX_W'(s)) begin
          module_shadow[s] <= wr_module;
          slot_shadow[s]   <= wr_slot;
          mask[s]          <= 1'b1;
        end
      end
    end
  end

  assign mask_full = &mask;

endmodule

// File: rtl/intc_benes_route_loader.sv
// Benes route loader: decodes SET/COMMIT commands and swaps the shadow bank into
// the active bank. Optional macro INTC_ROUTE_STAGGER_EN staggers the swap per stage.
module intc_benes_route_loader
  import intc_benes_route_loader_pkg::*;
#(
  parameter int STAGE_NUM = intc_benes_route_loader_pkg::STAGE_NUM,
  parameter int SEL_W     = 16,
  parameter int CYCLES    = intc_benes_route_loader_pkg::CYCLES
) (
  input  logic                            clk,
  input  logic                            rstn,
  intc_benes_route_loader_if.slave        i_cmd,
  input  logic                            i_intc_idle,
  input  logic                            i_err_clr,
  output logic                            o_ready,
  output logic [0:STAGE_NUM-1][SEL_W-1:0] o_module_select,
  output logic [0:STAGE_NUM-1][SEL_W-1:0] o_slot_select,
  output logic [7:0]                      o_epoch,
  output logic [2:0]                      o_err
);

  localparam logic [1:0] ST_IDLE       = ROUTE_IDLE;
  localparam logic [1:0] ST_WAIT_DRAIN = ROUTE_WAIT_DRAIN;
  localparam logic [1:0] ST_SWAP       = ROUTE_SWAP;
  localparam logic [1:0] ST_STAGGER    = ROUTE_STAGGER;

  logic [1:0] state, state_nxt;
  logic [7:0] stage_idx;
  logic       is_set, is_commit, accept, stage_ok;
  logic       set_ok, commit_full, swap_done;
  logic [2:0] err_set;
  logic       mask_full;
  logic [0:STAGE_NUM-1][SEL_W-1:0] module_shadow, slot_shadow;

  logic unused_data0_hi;
  assign unused_data0_hi = ^i_cmd.data0[DATA_W-1:8];

  // NOTE: every combinational output gets a default first so no path can
  // fall through and infer a latch.
  always_comb begin
    stage_idx   = i_cmd.data0[7:0];
    is_set      = (i_cmd.command == COMMAND_SET_ROUTE);
    is_commit   = (i_cmd.command == COMMAND_COMMIT_ROUTE);
    accept      = i_cmd.valid && o_ready;
    stage_ok    = (stage_idx < 8'(STAGE_NUM));
    set_ok      = accept && is_set && stage_ok;
    commit_full = accept && is_commit && mask_full;
    err_set                       = '0;
    err_set[ROUTE_ERR_DROP]       = i_cmd.valid && !o_ready && (is_set || is_commit);
    err_set[ROUTE_ERR_STAGE]      = accept && is_set && !stage_ok;
    err_set[ROUTE_ERR_INCOMPLETE] = accept && is_commit && !mask_full;
  end

  intc_route_shadow_bank #(
    .STAGE_NUM (STAGE_NUM),
    .SEL_W     (SEL_W),
    .IDX_W     (8)
  ) u_shadow (
    .clk           (clk),
    .rstn          (rstn),
    .wr_en         (set_ok),
    .wr_stage      (stage_idx),
    .wr_module     (SEL_W'(i_cmd.data1[15:0])),
    .wr_slot       (SEL_W'(i_cmd.data1[31:16])),
    .mask_clr      (swap_done),
    .module_shadow (module_shadow),
    .slot_shadow   (slot_shadow),
    .mask_full     (mask_full)
  );

`ifdef INTC_ROUTE_STAGGER_EN
  localparam int LAST_CNT = (STAGE_NUM - 1) * CYCLES;
  localparam int CNT_W    = (LAST_CNT > 0) ? $clog2(LAST_CNT + 1) : 1;

  logic [CNT_W-1:0] stag_cnt;
  logic [0:STAGE_NUM-1][SEL_W-1:0] stage_module, stage_slot;
  logic unused_idle;
  assign unused_idle = i_intc_idle;

  assign swap_done = (state == ST_STAGGER) && (stag_cnt == CNT_W'(LAST_CNT));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (commit_full) state_nxt = ST_STAGGER;
      ST_STAGGER: if (swap_done)   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Staging snapshot decouples the stagger from SETs issued after the commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stag_cnt     <= '0;
      stage_module <= '0;
      stage_slot   <= '0;
    end else if (commit_full) begin
      stag_cnt     <= '0;
      stage_module <= module_shadow;
      stage_slot   <= slot_shadow;
    end else if (state == ST_STAGGER) begin
      stag_cnt <= stag_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_module_select <= '0;
      o_slot_select   <= '0;
    end else if (state == ST_STAGGER) begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (stag_cnt == CNT_W'(s * CYCLES)) begin
          o_module_select[s] <= stage_module[s];
          o_slot_select[s]   <= stage_slot[s];
        end
      end
    end
  end
`else
  localparam int unused_cycles = CYCLES;
  logic unused_stagger_state;
  assign unused_stagger_state = (state == ST_STAGGER);

  assign swap_done = (state == ST_SWAP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (commit_full) state_nxt = ST_WAIT_DRAIN;
      ST_WAIT_DRAIN: if (i_intc_idle) state_nxt = ST_SWAP;
      ST_SWAP:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_module_select <= '0;
      o_slot_select   <= '0;
    end else if (swap_done) begin
      o_module_select <= module_shadow;
      o_slot_select   <= slot_shadow;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      o_ready <= 1'b1;
      o_epoch <= '0;
      o_err   <= '0;
    end else begin
      state   <= state_nxt;
      o_ready <= (state_nxt == ST_IDLE);
      if (swap_done) o_epoch <= o_epoch + 8'd1;
      // A set condition in the same cycle as the clear survives it.
      o_err   <= (o_err & {3{~i_err_clr}}) | err_set;
    end
  end

endmodule

// File: tb/tb_intc_benes_route_loader.sv
// Directed self-checking bench for the Benes route loader (drain and stagger builds).
module tb_intc_benes_route_loader;
  import intc_benes_route_loader_pkg::*;

  localparam int SEL_W = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic idle = 1'b1;
  logic err_clr = 1'b0;
  logic ready;
  logic [0:STAGE_NUM-1][SEL_W-1:0] mod_sel, slot_sel;
  logic [7:0] epoch;
  logic [2:0] err;

  int errors = 0;
  int checks = 0;

  intc_benes_route_loader_if cmd_if ();

  intc_benes_route_loader #(
    .STAGE_NUM (STAGE_NUM),
    .SEL_W     (SEL_W),
    .CYCLES    (CYCLES)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_cmd           (cmd_if.slave),
    .i_intc_idle     (idle),
    .i_err_clr       (err_clr),
    .o_ready         (ready),
    .o_module_select (mod_sel),
    .o_slot_select   (slot_sel),
    .o_epoch         (epoch),
    .o_err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] cmd, input logic [31:0] d0, input logic [31:0] d1);
    cmd_if.valid   = 1'b1;
    cmd_if.command = cmd;
    cmd_if.data0   = d0;
    cmd_if.data1   = d1;
    tick();
    cmd_if.valid   = 1'b0;
  endtask

  task automatic write_stages(input int n, input logic [15:0] mod_base, input logic [15:0] slot_base);
    for (int s = 0; s < n; s++)
      send(8'd30, 32'(s), {slot_base + 16'(s), mod_base + 16'(s)});
  endtask

  initial begin
    cmd_if.valid   = 1'b0;
    cmd_if.command = '0;
    cmd_if.data0   = '0;
    cmd_if.data1   = '0;

    repeat (2) tick();
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_epoch", 32'(epoch), 32'h0);
    check("rst_err",   32'(err),   32'h0);
    check("rst_mod0",  32'(mod_sel[0]),  32'h0);
    check("rst_slot8", 32'(slot_sel[8]), 32'h0);
    rstn = 1'b1;
    tick();

    write_stages(9, 16'h0200, 16'h0100);

`ifndef INTC_ROUTE_STAGGER_EN
    // Full commit with the network idle: swap two edges after the commit edge.
    send(8'd31, 32'h0, 32'h0);
    check("e0_ready", 32'(ready), 32'h0);
    check("e0_mod8",  32'(mod_sel[8]), 32'h0);
    tick();
    check("e1_ready", 32'(ready), 32'h0);
    check("e1_mod8",  32'(mod_sel[8]), 32'h0);
    tick();
    check("e2_mod8",  32'(mod_sel[8]),  32'h0208);
    check("e2_slot8", 32'(slot_sel[8]), 32'h0108);
    check("e2_mod0",  32'(mod_sel[0]),  32'h0200);
    check("e2_epoch", 32'(epoch), 32'h1);
    check("e2_ready", 32'(ready), 32'h1);

    // Incomplete shadow: commit rejected, nothing moves.
    write_stages(8, 16'hBB00, 16'hAA00);
    send(8'd31, 32'h0, 32'h0);
    check("inc_err",   32'(err),   32'h4);
    check("inc_ready", 32'(ready), 32'h1);
    tick();
    check("inc_ready2", 32'(ready), 32'h1);
    check("inc_mod0",  32'(mod_sel[0]), 32'h0200);
    check("inc_epoch", 32'(epoch), 32'h1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err", 32'(err), 32'h0);

    // Out-of-range stage; mask stays partial so the next commit still fails.
    send(8'd30, 32'h9, 32'h12345678);
    check("stage_err", 32'(err), 32'h2);
    send(8'd31, 32'h0, 32'h0);
    check("stage_mask", 32'(err), 32'h6);

    // Clear and a new set condition on the same edge: the set survives.
    err_clr = 1'b1;
    send(8'd30, 32'h9, 32'h0);
    err_clr = 1'b0;
    check("set_wins", 32'(err), 32'h2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err2", 32'(err), 32'h0);

    // Drain wait: completes the mask, commits with the network busy.
    idle = 1'b0;
    send(8'd30, 32'h8, 32'hAA08_BB08);
    send(8'd31, 32'h0, 32'h0);
    repeat (5) tick();
    send(8'd30, 32'h0, 32'hDEAD_BEEF);
    check("drop_err", 32'(err), 32'h1);
    repeat (14) tick();
    check("wait_ready", 32'(ready), 32'h0);
    check("wait_mod0",  32'(mod_sel[0]), 32'h0200);
    check("wait_epoch", 32'(epoch), 32'h1);
    idle = 1'b1;
    tick();
    check("swap_ready", 32'(ready), 32'h0);
    check("swap_mod0",  32'(mod_sel[0]), 32'h0200);
    tick();
    check("post_mod0",  32'(mod_sel[0]),  32'hBB00);
    check("post_slot0", 32'(slot_sel[0]), 32'hAA00);
    check("post_mod8",  32'(mod_sel[8]),  32'hBB08);
    check("post_slot8", 32'(slot_sel[8]), 32'hAA08);
    check("post_epoch", 32'(epoch), 32'h2);
    check("post_ready", 32'(ready), 32'h1);

    // Asynchronous reset in the middle of a drain wait.
    write_stages(9, 16'h3300, 16'h4400);
    idle = 1'b0;
    send(8'd31, 32'h0, 32'h0);
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    check("mrst_ready", 32'(ready), 32'h1);
    check("mrst_mod8",  32'(mod_sel[8]),  32'h0);
    check("mrst_slot0", 32'(slot_sel[0]), 32'h0);
    check("mrst_epoch", 32'(epoch), 32'h0);
    check("mrst_err",   32'(err),   32'h0);
    tick();
    rstn = 1'b1;
    idle = 1'b1;
    tick();
    send(8'd31, 32'h0, 32'h0);
    check("mrst_commit_err",   32'(err),   32'h4);
    check("mrst_commit_ready", 32'(ready), 32'h1);
    tick();
    check("mrst_commit_epoch", 32'(epoch), 32'h0);
`else
    // Staggered commit: stage s lands at E0+1+2s, epoch and ready at E0+17.
    idle = 1'b0;
    send(8'd31, 32'h0, 32'h0);
    check("stg_e0_ready", 32'(ready), 32'h0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) begin
        check("stg_k1_mod0", 32'(mod_sel[0]), 32'h0200);
        check("stg_k1_mod1", 32'(mod_sel[1]), 32'h0);
      end
      if (k == 8) check("stg_k8_mod4", 32'(mod_sel[4]), 32'h0);
      if (k == 9) check("stg_k9_mod4", 32'(mod_sel[4]), 32'h0204);
      if (k == 16) begin
        check("stg_k16_ready", 32'(ready), 32'h0);
        check("stg_k16_epoch", 32'(epoch), 32'h0);
        check("stg_k16_mod8",  32'(mod_sel[8]), 32'h0);
      end
      if (k == 17) begin
        check("stg_k17_mod8",  32'(mod_sel[8]),  32'h0208);
        check("stg_k17_slot8", 32'(slot_sel[8]), 32'h0108);
        check("stg_k17_ready", 32'(ready), 32'h1);
        check("stg_k17_epoch", 32'(epoch), 32'h1);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intc_benes_route_loader.md
# intc_benes_route_loader

Loads routing configuration for the Benes interconnect. It decodes route commands from the command stream into a shadow bank of per-stage select words, and swaps them atomically into the active bank on a commit command. It sits directly upstream of the Benes interconnect and drives that block's `i_module_select` / `i_slot_select` arrays, so a full routing pattern changes only when the network is safe to reconfigure.

## Interface
Parameters:
- `STAGE_NUM`, default 9: number of Benes stages (from the package).
- `SEL_W`, default 16: width of each select word.
- `CYCLES`, default 2: pipeline cycles per Benes stage. Used only when the stagger feature is compiled in.

Ports:
- `clk`  in  1: single clock.
- `rstn`  in  1: asynchronous, active-low reset.
- `i_cmd`  in  CommandDataPort: `valid`, `command`, `data0`, `data1`.
- `i_intc_idle`  in  1: Benes pipeline holds no in-flight data.
- `i_err_clr`  in  1: clears `o_err`.
- `o_ready`  out  1: loader accepts a command this cycle.
- `o_module_select`  out  [0:STAGE_NUM-1][SEL_W]: active module select per stage.
- `o_slot_select`  out  [0:STAGE_NUM-1][SEL_W]: active slot select per stage.
- `o_epoch`  out  8: count of completed commits; wraps 255→0.
- `o_err`  out  3: sticky error bits.
  - bit0: command dropped while busy.
  - bit1: stage index out of range.
  - bit2: commit issued with incomplete shadow.

## Operation
- Command accepted when `i_cmd.valid` and `o_ready` are both high. Other command codes are ignored silently.
- COMMAND_SET_ROUTE (30):
  - `s = data0[7:0]`.
  - Shadow module select for stage s ← `data1[15:0]`; shadow slot select for stage s ← `data1[31:16]`.
  - Sets written-mask bit s.
  - s ≥ STAGE_NUM: no write; sets `o_err[1]`.
  - Rewriting a stage before commit overwrites it; the last write wins.
- COMMAND_COMMIT_ROUTE (31):
  - Mask not all ones: commit ignored, `o_err[2]` set, state unchanged.
  - Mask all ones: enter WAIT_DRAIN.
- A valid command of either code while `o_ready` is low is dropped and sets `o_err[0]`.
- FSM (base build):
  - IDLE → WAIT_DRAIN on accepted full commit.
  - WAIT_DRAIN → SWAP when `i_intc_idle` is sampled high.
  - SWAP → IDLE after one cycle.
- SWAP cycle actions:
  - All active selects ← shadow.
  - Mask cleared; shadow contents retained.
  - `o_epoch` incremented.
- `o_ready` is high only in IDLE.
- `i_err_clr` clears all `o_err` bits. When a set condition and the clear occur in the same cycle, the set wins.
- Reset (any time, including mid-drain):
  - FSM → IDLE.
  - Active, shadow, mask, `o_epoch`, `o_err` all zero.
  - `o_ready` = 1.
  - No partial swap is ever visible.

## Timing
- Let E0 be the edge that accepts SET. The shadow and mask are updated at E0. A COMMIT accepted at E0+1 sees the new mask.
- Commit accepted at E0 with `i_intc_idle` high at E1:
  - SWAP occupies the cycle after E1.
  - New selects and `o_epoch` are visible after E2.
  - `o_ready` is low from E0 to E2 and high again after E2.
- While `i_intc_idle` stays low, the FSM holds WAIT_DRAIN indefinitely with outputs unchanged.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- Macro: `INTC_ROUTE_STAGGER_EN`.
- Defined:
  - Commit does not wait for `i_intc_idle`; WAIT_DRAIN and SWAP are replaced by state STAGGER.
  - At the commit edge E0, the shadow is snapshotted into a staging bank.
  - Stage s active selects update at edge E0+1+s·CYCLES, so each data wavefront sees one consistent pattern.
  - `o_epoch` increments and `o_ready` rises with the last stage update at E0+1+(STAGE_NUM-1)·CYCLES, which is E0+17 at defaults.
  - `i_intc_idle` is ignored.
- Undefined: drain-then-swap behaviour as described above. No staging bank and no stagger counter are built.

## Structure
- FHE_ALU_PKG gains:
  - Constants `COMMAND_SET_ROUTE` = 30 and `COMMAND_COMMIT_ROUTE` = 31.
  - Error-bit localparams `ROUTE_ERR_DROP` = 0, `ROUTE_ERR_STAGE` = 1, `ROUTE_ERR_INCOMPLETE` = 2.
  - A route FSM state enum.
- Existing `STAGE_NUM` and `CYCLES` are reused.
- One sub-module, `intc_route_shadow_bank`: shadow registers plus written mask, with write port and mask-full flag. The FSM and active bank stay in the top level.

## Test plan
- Write stages 0..8 with `data1` = {16'h0100+s, 16'h0200+s}, commit with idle=1 → selects visible 2 edges after commit; stage 8 reads `o_module_select` = 0x0208, `o_slot_select` = 0x0108; `o_epoch` = 1.
- Write stages 0..7 only, then commit → `o_err` = 3'b100, active stays 0, `o_ready` stays 1.
- SET with stage 9 → `o_err[1]` set, mask unchanged. Then `i_err_clr` → `o_err` = 0.
- Full commit with `i_intc_idle` = 0 for 20 cycles; SET issued during the wait → `o_err[0]` set, outputs unchanged until 2 edges after idle rises.
- Assert `rstn` low during WAIT_DRAIN → all outputs 0 and `o_ready` = 1 immediately. A subsequent commit is rejected (mask cleared).
- With `INTC_ROUTE_STAGGER_EN`, full commit → stage 0 updates at E0+1, stage 4 at E0+9, stage 8 at E0+17; `o_ready` and `o_epoch` change at E0+17.
